// File: rtl/video_timing_ctrl.sv
// Raster timing controller: sequences horizontal and vertical sync/porch/active
// periods on the pixel clock and decodes sync, blanking, coordinates and SOF.
module video_timing_ctrl #(
   parameter int H_DISP = 800,
   parameter int H_FP   = 40,
   parameter int H_SYNC = 48,
   parameter int H_BP   = 40,
   parameter int V_DISP = 480,
   parameter int V_FP   = 13,
   parameter int V_SYNC = 3,
   parameter int V_BP   = 29,
   localparam int XW    = $clog2(H_DISP),
   localparam int YW    = $clog2(V_DISP)
) (
   input  logic          video_CLK,
   input  logic          video_RST,
   input  logic          video_EN,
   output logic          video_HS,
   output logic          video_VS,
   output logic          video_BLANK,
   output logic [XW-1:0] video_X,
   output logic [YW-1:0] video_Y,
   output logic          video_SOF
);

   localparam int H_MAX_A = (H_DISP > H_FP) ? H_DISP : H_FP;
   localparam int H_MAX_B = (H_SYNC > H_BP) ? H_SYNC : H_BP;
   localparam int V_MAX_A = (V_DISP > V_FP) ? V_DISP : V_FP;
   localparam int V_MAX_B = (V_SYNC > V_BP) ? V_SYNC : V_BP;
   localparam int H_MAX   = (H_MAX_A > H_MAX_B) ? H_MAX_A : H_MAX_B;
   localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int ALL_MAX = (H_MAX > V_MAX) ? H_MAX : V_MAX;
   localparam int CW      = $clog2(ALL_MAX);

   localparam logic [1:0] ST_SYNC = 2'd0;
   localparam logic [1:0] ST_BP   = 2'd1;
   localparam logic [1:0] ST_ACT  = 2'd2;
   localparam logic [1:0] ST_FP   = 2'd3;

   localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC - 1);
   localparam logic [CW-1:0] H_BP_END   = CW'(H_BP - 1);
   localparam logic [CW-1:0] H_DISP_END = CW'(H_DISP - 1);
   localparam logic [CW-1:0] H_FP_END   = CW'(H_FP - 1);
   localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC - 1);
   localparam logic [CW-1:0] V_BP_END   = CW'(V_BP - 1);
   localparam logic [CW-1:0] V_DISP_END = CW'(V_DISP - 1);
   localparam logic [CW-1:0] V_FP_END   = CW'(V_FP - 1);

   logic [1:0]    h_state;
   logic [1:0]    v_state;
   logic [CW-1:0] hcnt;
   logic [CW-1:0] vcnt;
   logic [CW-1:0] h_end;
   logic [CW-1:0] v_end;
   logic          h_last;
   logic          v_last;
   logic          line_end;
   logic          h_act;
   logic          v_act;

   always_comb begin
      h_end = H_SYNC_END;
      case (h_state)
         ST_SYNC: h_end = H_SYNC_END;
         ST_BP:   h_end = H_BP_END;
         ST_ACT:  h_end = H_DISP_END;
         ST_FP:   h_end = H_FP_END;
         default: h_end = H_SYNC_END;
      endcase
      v_end = V_SYNC_END;
      case (v_state)
         ST_SYNC: v_end = V_SYNC_END;
         ST_BP:   v_end = V_BP_END;
         ST_ACT:  v_end = V_DISP_END;
         ST_FP:   v_end = V_FP_END;
         default: v_end = V_SYNC_END;
      endcase
   end

   assign h_last   = (hcnt == h_end);
   assign v_last   = (vcnt == v_end);
   assign line_end = (h_state == ST_FP) && h_last;

   // Disabling behaves like reset: the next enable always restarts a fresh frame.
   always_ff @(posedge video_CLK) begin
      if (video_RST || !video_EN) begin
         h_state <= ST_SYNC;
         v_state <= ST_SYNC;
         hcnt    <= '0;
         vcnt    <= '0;
      end else begin
         if (h_last) begin
            hcnt    <= '0;
            h_state <= h_state + 2'd1;
         end else begin
            hcnt <= hcnt + CW'(1);
         end
         if (line_end) begin
            if (v_last) begin
               vcnt    <= '0;
               v_state <= v_state + 2'd1;
            end else begin
               vcnt <= vcnt + CW'(1);
            end
         end
      end
   end

   assign h_act = (h_state == ST_ACT);
   assign v_act = (v_state == ST_ACT);

   assign video_HS    = !(video_EN && (h_state == ST_SYNC));
   assign video_VS    = !(video_EN && (v_state == ST_SYNC));
   assign video_BLANK = !(video_EN && h_act && v_act);
   assign video_X     = (video_EN && h_act) ? hcnt[XW-1:0] : '0;
   assign video_Y     = (video_EN && v_act) ? vcnt[YW-1:0] : '0;
   assign video_SOF   = video_EN && (h_state == ST_SYNC) && (hcnt == '0) &&
                        (v_state == ST_SYNC) && (vcnt == '0);

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl on a 15x10 raster: a frame-position
// model checked every cycle plus hand-computed timing expectations.
module tb_video_timing_ctrl;

   localparam int H_DISP = 8;
   localparam int H_FP   = 2;
   localparam int H_SYNC = 3;
   localparam int H_BP   = 2;
   localparam int V_DISP = 4;
   localparam int V_FP   = 2;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 2;
   localparam int LINE   = H_SYNC + H_BP + H_DISP + H_FP;
   localparam int LINES  = V_SYNC + V_BP + V_DISP + V_FP;
   localparam int FRAME  = LINE * LINES;

   logic       video_CLK = 1'b0;
   logic       video_RST = 1'b1;
   logic       video_EN  = 1'b0;
   logic       video_HS;
   logic       video_VS;
   logic       video_BLANK;
   logic [2:0] video_X;
   logic [1:0] video_Y;
   logic       video_SOF;

   int checks = 0;
   int errors = 0;
   int pos = 0;
   bit compare_on = 1'b0;

   video_timing_ctrl #(
      .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .video_CLK  (video_CLK),
      .video_RST  (video_RST),
      .video_EN   (video_EN),
      .video_HS   (video_HS),
      .video_VS   (video_VS),
      .video_BLANK(video_BLANK),
      .video_X    (video_X),
      .video_Y    (video_Y),
      .video_SOF  (video_SOF)
   );

   always #5 video_CLK = ~video_CLK;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en);
      @(posedge video_CLK);
      #1;
      video_RST = rst;
      video_EN  = en;
   endtask

   // Model: the raster is just a position within the frame, restarted by reset or disable.
   always @(posedge video_CLK) begin
      if (video_RST || !video_EN) pos <= 0;
      else                        pos <= (pos + 1) % FRAME;
   end

   always @(negedge video_CLK) begin
      if (compare_on) begin
         int hpos, line, ex, ey;
         bit hact, vact;
         hpos = pos % LINE;
         line = pos / LINE;
         hact = (hpos >= H_SYNC + H_BP) && (hpos < H_SYNC + H_BP + H_DISP);
         vact = (line >= V_SYNC + V_BP) && (line < V_SYNC + V_BP + V_DISP);
         ex   = hact ? hpos - (H_SYNC + H_BP) : 0;
         ey   = vact ? line - (V_SYNC + V_BP) : 0;
         if (!video_EN) begin
            checkOutput("model_hs", video_HS, 1);
            checkOutput("model_vs", video_VS, 1);
            checkOutput("model_blank", video_BLANK, 1);
            checkOutput("model_x", video_X, 0);
            checkOutput("model_y", video_Y, 0);
            checkOutput("model_sof", video_SOF, 0);
         end else begin
            checkOutput("model_hs", video_HS, int'(hpos >= H_SYNC));
            checkOutput("model_vs", video_VS, int'(line >= V_SYNC));
            checkOutput("model_blank", video_BLANK, int'(!(hact && vact)));
            checkOutput("model_x", video_X, ex);
            checkOutput("model_y", video_Y, ey);
            checkOutput("model_sof", video_SOF, int'(pos == 0));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit hs_rec[FRAME];
      bit vs_rec[FRAME];
      bit bl_rec[FRAME];
      bit sof_rec[FRAME];
      int x_rec[FRAME];
      int y_rec[FRAME];
      int cnt_hs, cnt_vs, cnt_bl, cnt_sof, first_bl, period;
      bit found;

      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      compare_on = 1'b1;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge video_CLK);
         checkOutput("idle_outputs",
                     {video_HS, video_VS, video_BLANK, video_X, video_Y, video_SOF},
                     {1'b1, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0});
      end

      // Enable and record one whole frame
      applyStimulus(1'b0, 1'b1);
      @(negedge video_CLK);
      checkOutput("en_first_sof", video_SOF, 1);
      checkOutput("en_first_hs", video_HS, 0);
      checkOutput("en_first_vs", video_VS, 0);
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge video_CLK);
         hs_rec[i]  = video_HS;
         vs_rec[i]  = video_VS;
         bl_rec[i]  = video_BLANK;
         sof_rec[i] = video_SOF;
         x_rec[i]   = video_X;
         y_rec[i]   = video_Y;
      end
      cnt_hs = 0; cnt_vs = 0; cnt_bl = 0; cnt_sof = 0; first_bl = -1;
      for (int i = 0; i < FRAME; i++) begin
         if (!hs_rec[i])  cnt_hs++;
         if (!vs_rec[i])  cnt_vs++;
         if (sof_rec[i])  cnt_sof++;
         if (!bl_rec[i]) begin
            cnt_bl++;
            if (first_bl < 0) first_bl = i;
         end
      end
      checkOutput("hs_low_per_frame", cnt_hs, 30);
      checkOutput("hs_line_pattern", {hs_rec[2], hs_rec[3], hs_rec[14], hs_rec[15]}, 4'b0110);
      checkOutput("active_per_frame", cnt_bl, 32);
      checkOutput("first_active", first_bl, 65);
      checkOutput("x_at_65", x_rec[65], 0);
      checkOutput("x_at_72", x_rec[72], 7);
      checkOutput("blank_at_73", bl_rec[73], 1);
      checkOutput("y_at_110", y_rec[110], 3);
      checkOutput("vs_low_count", cnt_vs, 30);
      checkOutput("vs_edge", {vs_rec[0], vs_rec[29], vs_rec[30]}, 3'b001);
      checkOutput("sof_per_frame", cnt_sof, 1);
      @(negedge video_CLK);
      checkOutput("sof_period", video_SOF, 1);

      // Drop enable mid-frame, then re-enable
      repeat (70) @(negedge video_CLK);
      checkOutput("f70_x", video_X, 5);
      checkOutput("f70_blank", video_BLANK, 0);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge video_CLK);
         checkOutput("disabled_idle", {video_HS, video_VS, video_BLANK, video_SOF}, 4'b1110);
         if (i < 4) applyStimulus(1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1);
      @(negedge video_CLK);
      checkOutput("reenable_sof", video_SOF, 1);
      checkOutput("reenable_hs_vs", {video_HS, video_VS}, 2'b00);

      // Reset during active pixel (4,2)
      repeat (99) @(negedge video_CLK);
      checkOutput("pix_x4", video_X, 4);
      checkOutput("pix_y2", video_Y, 2);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      @(negedge video_CLK);
      checkOutput("reset_sof", video_SOF, 1);
      found = 1'b0;
      period = 0;
      for (int i = 1; i <= 200 && !found; i++) begin
         @(negedge video_CLK);
         if (video_SOF) begin
            found  = 1'b1;
            period = i;
         end
      end
      checkOutput("restart_period", period, FRAME);

      compare_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
